// File: rtl/cb_cfg_loader_if.sv
// Configuration word stream and committed-image bus between the fabric
// configuration controller (master) and one connection-block loader (slave).
interface cb_cfg_loader_if #(
    parameter int CFG_SIZE   = 256,
    parameter int WORD_WIDTH = 32
);
    localparam int NUM_WORDS = (CFG_SIZE + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int CNT_W     = $clog2(NUM_WORDS + 1);

    logic                  cfg_start;
    logic [WORD_WIDTH-1:0] cfg_wdata;
    logic                  cfg_wvalid;
    logic                  cfg_wready;
    logic [CFG_SIZE-1:0]   cfg_out;
    logic                  cfg_busy;
    logic                  cfg_done;
    logic                  cfg_err;
    logic [CNT_W-1:0]      cfg_word_cnt;

    modport master (
        output cfg_start, cfg_wdata, cfg_wvalid,
        input  cfg_wready, cfg_out, cfg_busy, cfg_done, cfg_err, cfg_word_cnt
    );

    modport slave (
        input  cfg_start, cfg_wdata, cfg_wvalid,
        output cfg_wready, cfg_out, cfg_busy, cfg_done, cfg_err, cfg_word_cnt
    );
endinterface

// File: rtl/cb_cfg_loader.sv
// Connection-block configuration loader: assembles a word stream in a shadow
// register and commits it atomically to cfg_out. Optional XOR checksum beat: CB_CFG_CHECKSUM_EN.
module cb_cfg_loader #(
    parameter int CFG_SIZE   = 256,
    parameter int WORD_WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    cb_cfg_loader_if.slave   bus
);
    localparam int NUM_WORDS = (CFG_SIZE + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int SHADOW_W  = NUM_WORDS * WORD_WIDTH;
    localparam int CNT_W     = $clog2(NUM_WORDS + 1);
    localparam logic [CNT_W-1:0] C_LAST_DATA = CNT_W'(NUM_WORDS - 1);
    localparam logic [CNT_W-1:0] C_NUM_WORDS = CNT_W'(NUM_WORDS);

`ifdef CB_CFG_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, LOAD, CHECK, COMMIT} state_t;
`else
    typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;
`endif

    state_t                r_state;
    state_t                w_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [SHADOW_W-1:0]   r_shadow;
    logic [SHADOW_W-1:0]   w_shadow_next;
    logic [CFG_SIZE-1:0]   r_cfg_out;
    logic                  w_wready;
    logic                  w_accept;
    logic                  w_data_beat;
    logic                  w_restart;

    assign w_wready    = (r_state == LOAD) && !bus.cfg_start;
    assign w_accept    = w_wready && bus.cfg_wvalid;
    assign w_data_beat = w_accept && (r_cnt < C_NUM_WORDS);
    assign w_restart   = bus.cfg_start && ((r_state == IDLE) || (r_state == LOAD));

`ifdef CB_CFG_CHECKSUM_EN
    logic [WORD_WIDTH-1:0] r_xor;
    logic [WORD_WIDTH-1:0] r_csum;
    logic                  r_err;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (bus.cfg_start) w_next = LOAD;
`ifdef CB_CFG_CHECKSUM_EN
            LOAD:   if (w_accept && (r_cnt == C_NUM_WORDS)) w_next = CHECK;
            CHECK:  w_next = (r_csum == r_xor) ? COMMIT : IDLE;
`else
            LOAD:   if (w_accept && (r_cnt == C_LAST_DATA)) w_next = COMMIT;
`endif
            COMMIT: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // The last word is merged here so it can reach cfg_out on the same edge it is accepted.
    always_comb begin
        w_shadow_next = r_shadow;
        if (w_data_beat)
            w_shadow_next[int'(r_cnt) * WORD_WIDTH +: WORD_WIDTH] = bus.cfg_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow  <= '0;
            r_cfg_out <= '0;
            r_cnt     <= '0;
        end else begin
            r_shadow <= w_shadow_next;
            if (w_next == COMMIT)
                r_cfg_out <= w_shadow_next[CFG_SIZE-1:0];
            if (w_restart)
                r_cnt <= '0;
            else if (w_accept)
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

`ifdef CB_CFG_CHECKSUM_EN
    // Checksum covers the words as received, including bits later truncated away.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xor  <= '0;
            r_csum <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_restart)
                r_xor <= '0;
            else if (w_data_beat)
                r_xor <= r_xor ^ bus.cfg_wdata;
            if (w_accept && !w_data_beat)
                r_csum <= bus.cfg_wdata;
            if (r_state == CHECK)
                r_err <= (r_csum != r_xor);
        end
    end
    assign bus.cfg_err = r_err;
`else
    assign bus.cfg_err = 1'b0;
`endif

    assign bus.cfg_wready   = w_wready;
    assign bus.cfg_out      = r_cfg_out;
    assign bus.cfg_busy     = (r_state != IDLE);
    assign bus.cfg_done     = (r_state == COMMIT);
    assign bus.cfg_word_cnt = r_cnt;
endmodule
